multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// Sequencing controller for the multi-cycle RV32I datapath. It replaces the single-cycle opcode decoder.
// An FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Memory accesses use a req/ready handshake.
// The block latches the opcode, handles stall and memory timeout, traps illegal opcodes and counts retired instructions.
// PARAMETERS
// OPCODE_W    7   opcode field width
// ALUOP_W     2   ALUOp width; 00 ld/st add, 01 branch sub, 10 R-type/funct decode
// TMO_CYCLES  15  max wait cycles for mem_ready before trapping (>=1)
// RET_W       32  width of retired-instruction counter
// PORTS
// clk        in   1         clock, rising edge
// rst_n      in   1         async active-low reset
// opcode     in   OPCODE_W  instr[6:0] from IR; valid from DECODE onward
// zero       in   1         ALU zero flag (branch compare)
// mem_ready  in   1         memory completes access this cycle
// stall      in   1         hold current state, suppress all strobes
// mem_req    out  1         memory access request
// mem_read   out  1         read access (fetch or LW)
// mem_write  out  1         write access (SW)
// ir_write   out  1         load IR from memory data
// pc_write   out  1         update PC
// pc_src     out  1         0: PC+4, 1: branch target
// alu_src    out  1         0: rs2, 1: immediate
// mem_to_reg out  1         0: ALU result, 1: memory data to rd
// reg_write  out  1         write rd
// alu_op     out  ALUOP_W   ALU operation class
// instr_done out  1         one-cycle pulse, instruction retired
// illegal    out  1         sticky: unsupported opcode trapped
// timeout    out  1         sticky: mem_ready not seen within TMO_CYCLES
// state      out  3         current FSM state (debug)
// retired    out  RET_W     retired-instruction count, wraps modulo 2^RET_W
// BEHAVIOUR
// - Encodings: BOOT=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6.
// - Legal opcodes: R 0110011, ADDI 0010011, LW 0000011, SW 0100011, BEQ 1100011.
// - Reset: async to BOOT. opcode_q, timeout counter, retired, illegal and timeout all go to 0. Every output is 0 in BOOT.
// - BOOT: outputs 0; next state FETCH.
// - FETCH: mem_req=mem_read=1. On mem_ready: ir_write=pc_write=1, pc_src=0, go to DECODE.
// - DECODE: opcode_q<=opcode. Legal opcode -> EXEC; illegal -> TRAP with illegal<=1.
// - EXEC (uses opcode_q):
//   - R: alu_op=10, alu_src=0, go to WB.
//   - ADDI: alu_op=10, alu_src=1, go to WB.
//   - LW/SW: alu_op=00, alu_src=1, go to MEM.
//   - BEQ: alu_op=01, alu_src=0, pc_write=zero, pc_src=1, instr_done=1, go to FETCH.
// - MEM: mem_req=1, alu_op=00, alu_src=1, mem_read=(LW), mem_write=(SW). Wait for mem_ready.
//   - LW -> WB.
//   - SW -> FETCH with instr_done=1.
// - WB: reg_write=1, mem_to_reg=(LW), instr_done=1, go to FETCH.
// - TRAP: all strobes 0; state held until rst_n. illegal and timeout hold their values.
// - Wait counter:
//   - Clears on entry to FETCH/MEM and on mem_ready. Increments each non-stalled cycle in FETCH/MEM without mem_ready.
//   - Reaching TMO_CYCLES without mem_ready -> TRAP, timeout<=1.
//   - mem_ready on the same cycle as the limit wins: normal advance, no trap.
// - Stall=1: state, opcode_q and wait counter hold. mem_req, mem_read, mem_write, ir_write, pc_write, reg_write and instr_done are forced 0.
//   - mem_ready is ignored (the slave never sees a request). Stall has no effect in BOOT/TRAP.
// - retired increments by 1 on each instr_done cycle and wraps from all-ones to 0.
// - Latency with mem_ready the same cycle as the request:
//   - R/ADDI/BEQ: 4 cycles (BEQ 3).
//   - LW: 5 cycles; SW: 4 cycles.
// - All outputs are decoded from state/opcode_q/zero/stall/mem_ready. No output depends on raw opcode outside DECODE.
// TESTING
// - Reset release, mem_ready tied 1:
//   - Expect state 0 -> 1, one BOOT cycle, all outputs 0.
//   - ADDI: FETCH/DECODE/EXEC/WB, then reg_write=1, alu_src=1, instr_done=1, retired=1.
// - LW with mem_ready delayed 3 cycles in both FETCH and MEM:
//   - mem_req stays high 4 cycles each.
//   - WB has mem_to_reg=1; total 11 cycles; retired +1.
// - BEQ with zero=1 -> EXEC has pc_write=1, pc_src=1, alu_op=01. With zero=0 -> pc_write=0. Both cycles pulse instr_done.
// - Opcode 0110111 -> DECODE moves to TRAP, illegal=1. Stays in TRAP for 20 cycles; reset clears illegal.
// - mem_ready held 0 in FETCH:
//   - After TMO_CYCLES=15 cycles: TRAP, timeout=1.
//   - Repeat with ready on cycle 15: no trap, DECODE entered.
// - Stall 5 cycles mid-MEM on SW: mem_write=0 during stall, state=4 held, counter frozen, then normal completion.
//   - Also assert rst_n=0 mid-EXEC -> immediate BOOT, retired=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memory.
//   mem_req   : controller -> memory, an access is requested this cycle
//   mem_read  : controller -> memory, the access is a read (fetch or LW)
//   mem_write : controller -> memory, the access is a write (SW)
//   mem_ready : memory -> controller, the access completes this cycle
//
// Handshake: an access completes on a rising clock edge where mem_req and
// mem_ready are both 1. mem_req stays high, and the access type stays
// constant, until that edge. The memory may raise mem_ready at any time. The
// controller only acts on it while it is driving mem_req, so a mem_ready seen
// while mem_req is low (for example during a stall) has no effect.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_read,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing controller for a multi-cycle RV32I datapath.
// Each instruction passes through FETCH / DECODE / EXEC / MEM / WB. The
// controller latches the opcode in DECODE, waits on the memory handshake and
// traps on an illegal opcode or a memory timeout. It also counts retired
// instructions.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   mem          : memory handshake (master side), see multicycle_controller_if
//   opcode       : instr[6:0] from the IR, sampled only in DECODE
//   zero         : ALU zero flag, used for the BEQ decision in EXEC
//   stall        : hold state, opcode and wait counter; force strobes to 0
//   ir_write     : load the IR from memory data
//   pc_write     : update the PC
//   pc_src       : 0 = PC+4, 1 = branch target
//   alu_src      : 0 = rs2, 1 = immediate
//   mem_to_reg   : 0 = ALU result, 1 = memory data to rd
//   reg_write    : write rd
//   alu_op       : 00 = add (ld/st), 01 = sub (branch), 10 = funct decode
//   instr_done   : one-cycle pulse when an instruction retires
//   illegal      : sticky, an unsupported opcode was trapped
//   timeout      : sticky, mem_ready did not arrive within TMO_CYCLES
//   state        : current FSM state (debug)
//   retired      : retired-instruction count, wraps modulo 2^RET_W
module multicycle_controller #(
  parameter int OPCODE_W   = 7,
  parameter int ALUOP_W    = 2,
  parameter int TMO_CYCLES = 15,
  parameter int RET_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_controller_if.master    mem,
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic                       zero,
  input  logic                       stall,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       pc_src,
  output logic                       alu_src,
  output logic                       mem_to_reg,
  output logic                       reg_write,
  output logic [ALUOP_W-1:0]         alu_op,
  output logic                       instr_done,
  output logic                       illegal,
  output logic                       timeout,
  output logic [2:0]                 state,
  output logic [RET_W-1:0]           retired
);

  localparam int CNT_W = $clog2(TMO_CYCLES + 1);
  // The wait that lands on this count is the last one allowed. If mem_ready
  // is still low on that cycle, the controller traps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(7'b1100011);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                illegal_q, timeout_q;
  logic [RET_W-1:0]    retired_q;

  logic load_op;
  logic ill_set;
  logic tmo_set;
  logic is_lw;
  logic is_sw;
  logic op_legal;

  logic req_c, read_c, write_c, irw_c, pcw_c, regw_c, done_c;
  logic pc_src_c, alu_src_c, m2r_c;
  logic [ALUOP_W-1:0] alu_op_c;

  assign is_lw = (opcode_q == OP_LW);
  assign is_sw = (opcode_q == OP_SW);

  // Legality is judged on the raw opcode. Only DECODE uses this result.
  assign op_legal = (opcode == OP_R)  || (opcode == OP_ADDI) ||
                    (opcode == OP_LW) || (opcode == OP_SW)   ||
                    (opcode == OP_BEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      cnt_q     <= '0;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_op) opcode_q <= opcode;
      if (ill_set) illegal_q <= 1'b1;
      if (tmo_set) timeout_q <= 1'b1;
      if (done_c)  retired_q <= retired_q + RET_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_op   = 1'b0;
    ill_set   = 1'b0;
    tmo_set   = 1'b0;
    req_c     = 1'b0;
    read_c    = 1'b0;
    write_c   = 1'b0;
    irw_c     = 1'b0;
    pcw_c     = 1'b0;
    regw_c    = 1'b0;
    done_c    = 1'b0;
    pc_src_c  = 1'b0;
    alu_src_c = 1'b0;
    m2r_c     = 1'b0;
    alu_op_c  = ALU_ADD;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        req_c  = 1'b1;
        read_c = 1'b1;
        if (!stall) begin
          if (mem.mem_ready) begin
            irw_c   = 1'b1;
            pcw_c   = 1'b1;
            state_d = S_DECODE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_TRAP;
            tmo_set = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DECODE: begin
        if (!stall) begin
          load_op = 1'b1;
          if (op_legal) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_TRAP;
            ill_set = 1'b1;
          end
        end
      end

      S_EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op_c = ALU_FUNCT;
            if (!stall) state_d = S_WB;
          end
          OP_ADDI: begin
            alu_op_c  = ALU_FUNCT;
            alu_src_c = 1'b1;
            if (!stall) state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            if (!stall) state_d = S_MEM;
          end
          OP_BEQ: begin
            // The branch resolves here, so the instruction retires in EXEC.
            alu_op_c = ALU_SUB;
            pc_src_c = 1'b1;
            pcw_c    = zero;
            done_c   = 1'b1;
            if (!stall) state_d = S_FETCH;
          end
          default: begin
            // opcode_q always holds a legal opcode when EXEC is reached.
            if (!stall) state_d = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        req_c     = 1'b1;
        alu_src_c = 1'b1;
        read_c    = is_lw;
        write_c   = is_sw;
        if (!stall) begin
          if (mem.mem_ready) begin
            if (is_lw) begin
              state_d = S_WB;
            end else begin
              done_c  = 1'b1;
              state_d = S_FETCH;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_TRAP;
            tmo_set = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WB: begin
        regw_c = 1'b1;
        m2r_c  = is_lw;
        done_c = 1'b1;
        if (!stall) state_d = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase

    // Any state change either enters a new state or answers a mem_ready.
    // In both cases the wait count starts over.
    if (state_d != state_q) cnt_d = '0;

    // During a stall every strobe that commits work is suppressed. The memory
    // never sees a request, so a mem_ready it raises in this window is ignored.
    if (stall) begin
      req_c   = 1'b0;
      read_c  = 1'b0;
      write_c = 1'b0;
      irw_c   = 1'b0;
      pcw_c   = 1'b0;
      regw_c  = 1'b0;
      done_c  = 1'b0;
    end
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_read  = read_c;
  assign mem.mem_write = write_c;
  assign ir_write      = irw_c;
  assign pc_write      = pcw_c;
  assign pc_src        = pc_src_c;
  assign alu_src       = alu_src_c;
  assign mem_to_reg    = m2r_c;
  assign reg_write     = regw_c;
  assign alu_op        = alu_op_c;
  assign instr_done    = done_c;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;
  assign state         = state_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Each instruction is described at the
// instruction level: opcode, memory wait cycles, stall cycles and the zero
// flag. A reference model expands that description into the expected
// per-cycle trace, which goes into a queue. Every queued cycle then drives the
// DUT inputs and compares all DUT outputs against the trace.
module tb_multicycle_controller;

  localparam int RW  = 4;   // small counter width so the wrap is reached
  localparam int TMO = 15;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b0110111;

  localparam logic [2:0] ST_BOOT = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_TRAP = 3'd6;

  typedef struct packed {
    logic [2:0]    st;
    logic          req, rd, wr, irw, pcw, pcs, alus, m2r, rw;
    logic [1:0]    aop;
    logic          done, ill, tmo;
    logic [RW-1:0] ret;
  } obs_t;

  typedef struct {
    logic       rdy, stl, zr;
    logic [6:0] opc;
    obs_t       e;
  } rec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic zero = 1'b0;
  logic stall = 1'b0;
  logic ir_write, pc_write, pc_src, alu_src, mem_to_reg, reg_write;
  logic [1:0] alu_op;
  logic instr_done, illegal, timeout;
  logic [2:0] state;
  logic [RW-1:0] retired;

  multicycle_controller_if mem_bus ();

  always #5 clk = ~clk;

  multicycle_controller #(
    .OPCODE_W(7), .ALUOP_W(2), .TMO_CYCLES(TMO), .RET_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem_bus),
    .opcode(opcode), .zero(zero), .stall(stall),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
    .timeout(timeout), .state(state), .retired(retired)
  );

  // ---------------- reference model state ----------------
  rec_t          exp_q[$];
  logic [RW-1:0] m_ret;
  logic          m_ill, m_tmo;
  int            n_vec = 0;
  int            n_err = 0;
  string         tag = "init";
  logic [6:0]    legal_ops [5] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};

  // A cycle where nothing is expected except the state. Opcode and zero are
  // random so that any leak of the raw inputs into the outputs shows up.
  function automatic rec_t mk(input logic [2:0] st);
    rec_t r;
    r.rdy  = 1'b0;
    r.stl  = 1'b0;
    r.zr   = 1'($urandom_range(0, 1));
    r.opc  = 7'($urandom);
    r.e    = '0;
    r.e.st = st;
    return r;
  endfunction

  task automatic push(input rec_t r);
    r.e.ill = m_ill;
    r.e.tmo = m_tmo;
    r.e.ret = m_ret;
    if (r.e.done) m_ret = m_ret + RW'(1);
    exp_q.push_back(r);
  endtask

  // A memory phase: w1 waits, then ns stalled cycles, then w2 waits, then
  // the ready cycle. When TMO unstalled waits have gone by, the phase ends in
  // a trap instead.
  task automatic mem_phase(input logic [2:0] st, input logic [6:0] op,
                           input int w1, input int ns, input int w2,
                           output bit trapped);
    rec_t r;
    int waits;
    waits = 0;
    trapped = 0;
    for (int i = 0; i < w1 + ns + w2; i++) begin
      r = mk(st);
      r.e.req = 1'b1;
      if (st == ST_FETCH) begin
        r.e.rd = 1'b1;
      end else begin
        r.e.alus = 1'b1;
        r.e.rd   = (op == OP_LW);
        r.e.wr   = (op == OP_SW);
      end
      if (i >= w1 && i < w1 + ns) begin
        r.stl  = 1'b1;
        r.rdy  = 1'($urandom_range(0, 1));
        r.e.req = 1'b0;
        r.e.rd  = 1'b0;
        r.e.wr  = 1'b0;
        push(r);
      end else begin
        push(r);
        waits++;
        if (waits == TMO) begin
          m_tmo = 1'b1;
          trapped = 1;
          return;
        end
      end
    end
    r = mk(st);
    r.rdy   = 1'b1;
    r.e.req = 1'b1;
    if (st == ST_FETCH) begin
      r.e.rd  = 1'b1;
      r.e.irw = 1'b1;
      r.e.pcw = 1'b1;
    end else begin
      r.e.alus = 1'b1;
      r.e.rd   = (op == OP_LW);
      r.e.wr   = (op == OP_SW);
      r.e.done = (op == OP_SW);
    end
    push(r);
  endtask

  task automatic push_trap(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = mk(ST_TRAP);
      r.stl = 1'($urandom_range(0, 1));
      r.rdy = 1'($urandom_range(0, 1));
      push(r);
    end
  endtask

  task automatic gen_instr(input logic [6:0] op,
                           input int fw1, input int fs, input int fw2,
                           input int mw1, input int ms, input int mw2,
                           input logic zv);
    rec_t r;
    bit trapped;
    mem_phase(ST_FETCH, op, fw1, fs, fw2, trapped);
    if (trapped) begin push_trap(20); return; end
    r = mk(ST_DECODE);
    r.opc = op;
    push(r);
    if (!(op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ})) begin
      m_ill = 1'b1;
      push_trap(20);
      return;
    end
    r = mk(ST_EXEC);
    case (op)
      OP_R:    r.e.aop = 2'b10;
      OP_ADDI: begin r.e.aop = 2'b10; r.e.alus = 1'b1; end
      OP_BEQ:  begin
        r.zr = zv; r.e.aop = 2'b01; r.e.pcs = 1'b1;
        r.e.pcw = zv; r.e.done = 1'b1;
      end
      default: r.e.alus = 1'b1;
    endcase
    push(r);
    if (op == OP_LW || op == OP_SW) begin
      mem_phase(ST_MEM, op, mw1, ms, mw2, trapped);
      if (trapped) begin push_trap(20); return; end
    end
    if (op != OP_BEQ && op != OP_SW) begin
      r = mk(ST_WB);
      r.e.rw   = 1'b1;
      r.e.m2r  = (op == OP_LW);
      r.e.done = 1'b1;
      push(r);
    end
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic check(input obs_t e);
    obs_t o;
    o.st   = state;
    o.req  = mem_bus.mem_req;
    o.rd   = mem_bus.mem_read;
    o.wr   = mem_bus.mem_write;
    o.irw  = ir_write;
    o.pcw  = pc_write;
    o.pcs  = pc_src;
    o.alus = alu_src;
    o.m2r  = mem_to_reg;
    o.rw   = reg_write;
    o.aop  = alu_op;
    o.done = instr_done;
    o.ill  = illegal;
    o.tmo  = timeout;
    o.ret  = retired;
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s vec %0d: observed %h expected %h", tag, n_vec, o, e);
    end
  endtask

  // Entered at posedge+1. Drives one cycle, compares at the falling edge,
  // and returns at the next posedge+1.
  task automatic run_n(input int k);
    rec_t r;
    for (int i = 0; i < k && exp_q.size() > 0; i++) begin
      r = exp_q.pop_front();
      mem_bus.mem_ready = r.rdy;
      stall  = r.stl;
      zero   = r.zr;
      opcode = r.opc;
      @(negedge clk);
      check(r.e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_all();
    run_n(exp_q.size());
  endtask

  task automatic do_reset();
    obs_t z;
    rec_t r;
    rst_n = 1'b0;
    #1;
    m_ret = '0;
    m_ill = 1'b0;
    m_tmo = 1'b0;
    z = '0;
    check(z);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = mk(ST_BOOT);
    r.stl = 1'($urandom_range(0, 1));
    r.rdy = 1'($urandom_range(0, 1));
    push(r);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    mem_bus.mem_ready = 1'b0;
    #2;
    tag = "reset";       do_reset();
    tag = "addi_rdy";    gen_instr(OP_ADDI, 0, 0, 0, 0, 0, 0, 1'b0); run_all();
    tag = "lw_delay3";   gen_instr(OP_LW, 3, 0, 0, 3, 0, 0, 1'b0);   run_all();
    tag = "beq_taken";   gen_instr(OP_BEQ, 0, 0, 0, 0, 0, 0, 1'b1);  run_all();
    tag = "beq_not";     gen_instr(OP_BEQ, 0, 0, 0, 0, 0, 0, 1'b0);  run_all();
    tag = "r_type";      gen_instr(OP_R, 1, 0, 0, 0, 0, 0, 1'b0);    run_all();
    tag = "sw_plain";    gen_instr(OP_SW, 0, 0, 0, 0, 0, 0, 1'b0);   run_all();
    tag = "sw_stall";    gen_instr(OP_SW, 0, 0, 0, 5, 5, 9, 1'b0);   run_all();
    tag = "fetch_limit"; gen_instr(OP_ADDI, 14, 0, 0, 0, 0, 0, 1'b0); run_all();

    tag = "random";
    for (int n = 0; n < 40; n++) begin
      gen_instr(legal_ops[$urandom_range(0, 4)],
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4),
                1'($urandom_range(0, 1)));
      run_all();
    end

    tag = "mid_exec_rst";
    gen_instr(OP_ADDI, 0, 0, 0, 0, 0, 0, 1'b0);
    run_n(2);
    exp_q.delete();
    mem_bus.mem_ready = 1'b1;
    #3;
    do_reset();
    run_all();

    tag = "illegal";     gen_instr(OP_BAD, 0, 0, 0, 0, 0, 0, 1'b0);  run_all();
    tag = "ill_clear";   do_reset(); run_all();
    tag = "fetch_tmo";   gen_instr(OP_ADDI, 15, 0, 0, 0, 0, 0, 1'b0); run_all();
    tag = "tmo_clear";   do_reset();
    tag = "after_tmo";   gen_instr(OP_ADDI, 0, 0, 0, 0, 0, 0, 1'b0); run_all();
    tag = "mem_tmo";     gen_instr(OP_LW, 0, 0, 0, 8, 2, 7, 1'b0);   run_all();
    tag = "final_rst";   do_reset(); run_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
